mac_driver: RTL and testbench
=============================

MAC_DRIVER -- requirements
Module: mac_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning operand-pair buffer depth (power of two).
REQ-002 SHALL have parameter WIDTH, default 16, meaning operand and result width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_a  input  WIDTH  operand A of the offered pair.
REQ-007 SHALL have port in_b  input  WIDTH  operand B of the offered pair.
REQ-008 SHALL have port in_ready  output  1  pair accepted when in_valid&in_ready at a clock edge.
REQ-009 SHALL have port start  input  1  single-cycle request to run the buffered pairs through the MAC.
REQ-010 SHALL have port mac_a  output  WIDTH  drives MAC input a.
REQ-011 SHALL have port mac_b  output  WIDTH  drives MAC input b.
REQ-012 SHALL have port mac_rst  output  1  drives MAC rst (clears accumulator).
REQ-013 SHALL have port mac_op  input  WIDTH  MAC accumulator output op.
REQ-014 SHALL have port res_valid  output  1  result available.
REQ-015 SHALL have port res_data  output  WIDTH  captured accumulated result.
REQ-016 SHALL have port res_ready  input  1  consumer accepts result.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port fill  output  log2(DEPTH)+1  number of buffered pairs.

Function
REQ-019 SHALL treat the MAC as: op <= op + a*b (mod 2^WIDTH) every rising edge when rst low, op <= 0 when rst high.
REQ-020 SHALL implement states IDLE, CLEAR, FEED, WAIT, DONE.
REQ-021 SHALL assert in_ready = (state==IDLE) & (fill<DEPTH) & !start; start has priority over a same-cycle push.
REQ-022 SHALL buffer accepted pairs in FIFO order; pointers wrap modulo DEPTH.
REQ-023 IDLE: start=1 -> CLEAR, irrespective of fill (including fill=0); start outside IDLE SHALL be ignored.
REQ-024 CLEAR: mac_rst=1 for exactly one cycle; next FEED if fill>0, else WAIT.
REQ-025 FEED: mac_a/mac_b SHALL equal FIFO head; one pair popped per cycle; after the pop that makes fill=0 -> WAIT.
REQ-026 Outside FEED, mac_a and mac_b SHALL be 0 so the accumulator holds.
REQ-027 WAIT: one cycle; res_data <= mac_op at its closing edge; -> DONE.
REQ-028 DONE: res_valid=1, res_data stable until res_valid&res_ready, then -> IDLE with res_valid=0 next cycle.
REQ-029 Latency: start sampled at edge t -> res_valid high in cycle t+3+N (N = pairs, N>=1); N=0 -> t+2.
REQ-030 Result SHALL be the WIDTH-bit wrapped sum; no saturation, no overflow flag.
REQ-031 mac_rst SHALL be 0 except in CLEAR and while rst is high.

Reset
REQ-032 rst high SHALL force state IDLE, fill=0, FIFO pointers 0, res_valid=0, res_data=0, mac_a=0, mac_b=0, mac_rst=1, busy=0, in_ready=0 during reset.
REQ-033 rst asserted in any state (including mid-FEED) SHALL discard buffered pairs and any pending result; first cycle after release is IDLE with in_ready=1.

Verification
REQ-034 Push (2,3),(4,5); start -> CLEAR, 2 FEED cycles, res_valid 5 cycles after start edge, res_data=26.
REQ-035 Push (300,300); start -> res_data=24464 (90000 mod 65536).
REQ-036 Start with fill=0 -> res_valid at start+2, res_data=0, mac_a/mac_b stay 0.
REQ-037 Push 8 pairs (1,1) with in_valid held -> in_ready low after 8th, 9th not accepted, fill=8; run -> res_data=8.
REQ-038 Hold res_ready=0 for 5 cycles in DONE -> res_valid=1, res_data constant, busy=1, start ignored; res_ready=1 -> IDLE next cycle.
REQ-039 Push 4 pairs, start, assert rst on 2nd FEED cycle -> fill=0, res_valid=0, mac_rst=1; new run of (7,6) -> res_data=42.

Source files
------------

// File: rtl/mac_driver.sv
// Sequencer that buffers operand pairs and streams them through an external
// multiply-accumulate unit, then captures and hands off the accumulated result.
module mac_driver #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     in_ready,
    input  logic                     start,
    output logic [WIDTH-1:0]         mac_a,
    output logic [WIDTH-1:0]         mac_b,
    output logic                     mac_rst,
    input  logic [WIDTH-1:0]         mac_op,
    output logic                     res_valid,
    output logic [WIDTH-1:0]         res_data,
    input  logic                     res_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // state   | meaning
    // S_IDLE  | accept pairs, wait for start
    // S_CLEAR | pulse mac_rst to zero the accumulator
    // S_FEED  | present FIFO head and pop; one drain cycle once empty
    // S_WAIT  | capture mac_op into res_data
    // S_DONE  | hold result until consumer takes it
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_fill;
    logic [WIDTH-1:0]   r_res_data;
    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CLEAR;
            S_CLEAR: w_next_state = (r_fill != '0) ? S_FEED : S_WAIT;
            S_FEED:  if (r_fill == '0) w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_DONE;
            S_DONE:  if (res_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // start wins over a same-cycle push so the run sees a stable pair count
    assign w_in_ready   = !rst && (r_state == S_IDLE) && (r_fill != FULL) && !start;
    assign w_push       = in_valid && w_in_ready;
    assign w_pop        = (r_state == S_FEED) && (r_fill != '0);
    assign w_head_valid = w_pop && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_res_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_fill <= r_fill + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_fill <= r_fill - (AW+1)'(1);
            if (r_state == S_WAIT) r_res_data <= mac_op;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // zero operands outside FEED keep the accumulator holding its value
    assign mac_a     = w_head_valid ? r_mem_a[r_rd_ptr] : '0;
    assign mac_b     = w_head_valid ? r_mem_b[r_rd_ptr] : '0;
    assign mac_rst   = rst || (r_state == S_CLEAR);
    assign in_ready  = w_in_ready;
    assign busy      = !rst && (r_state != S_IDLE);
    assign res_valid = !rst && (r_state == S_DONE);
    assign res_data  = r_res_data;
    assign fill      = r_fill;

endmodule

// File: tb/tb_mac_driver.sv
// Directed bench for mac_driver with a behavioural accumulator on the MAC side.
module tb_mac_driver;
    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ready;
    logic             start;
    logic [WIDTH-1:0] mac_a;
    logic [WIDTH-1:0] mac_b;
    logic             mac_rst;
    logic [WIDTH-1:0] mac_op;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_ready;
    logic             busy;
    logic [3:0]       fill;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_driver #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .start(start), .mac_a(mac_a), .mac_b(mac_b),
        .mac_rst(mac_rst), .mac_op(mac_op), .res_valid(res_valid),
        .res_data(res_data), .res_ready(res_ready), .busy(busy), .fill(fill)
    );

    // accumulator: op <= op + a*b, cleared by mac_rst
    always @(posedge clk) begin
        if (mac_rst) mac_op <= '0;
        else         mac_op <= mac_op + mac_a * mac_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic run_start(output int lat);
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        if (res_valid !== 1'b1) lat = -1;
    endtask

    task automatic ack;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0;
        tick; tick;
        total++; if (fill !== 4'd0)       begin bad++; $display("FAIL reset_fill: got %0d want 0", fill); end
        total++; if (res_valid !== 1'b0)  begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        total++; if (res_data !== 16'd0)  begin bad++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
        total++; if (mac_a !== 16'd0)     begin bad++; $display("FAIL reset_mac_a: got %0d want 0", mac_a); end
        total++; if (mac_b !== 16'd0)     begin bad++; $display("FAIL reset_mac_b: got %0d want 0", mac_b); end
        total++; if (mac_rst !== 1'b1)    begin bad++; $display("FAIL reset_mac_rst: got %b want 1", mac_rst); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        total++; if (mac_rst !== 1'b0)    begin bad++; $display("FAIL release_mac_rst: got %b want 0", mac_rst); end
    endtask

    task automatic test_basic;
        push(16'd2, 16'd3);
        push(16'd4, 16'd5);
        total++; if (fill !== 4'd2) begin bad++; $display("FAIL basic_fill: got %0d want 2", fill); end
        in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; start = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_start_prio: got in_ready=%b want 0", in_ready); end
        tick;
        in_valid = 1'b0; start = 1'b0;
        total++; if (fill !== 4'd2)    begin bad++; $display("FAIL basic_push_blocked: got fill=%0d want 2", fill); end
        total++; if (mac_rst !== 1'b1) begin bad++; $display("FAIL basic_clear: got mac_rst=%b want 1", mac_rst); end
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        tick;
        total++; if (mac_a !== 16'd2 || mac_b !== 16'd3 || mac_rst !== 1'b0)
            begin bad++; $display("FAIL basic_feed1: got a=%0d b=%0d rst=%b want 2 3 0", mac_a, mac_b, mac_rst); end
        tick;
        total++; if (mac_a !== 16'd4 || mac_b !== 16'd5)
            begin bad++; $display("FAIL basic_feed2: got a=%0d b=%0d want 4 5", mac_a, mac_b); end
        tick;
        total++; if (mac_a !== 16'd0 || mac_b !== 16'd0 || res_valid !== 1'b0)
            begin bad++; $display("FAIL basic_drain: got a=%0d b=%0d valid=%b want 0 0 0", mac_a, mac_b, res_valid); end
        tick;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_wait: got res_valid=%b want 0", res_valid); end
        tick;
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: got res_valid=%b want 1 at start+5", res_valid); end
        total++; if (res_data !== 16'd26) begin bad++; $display("FAIL basic_result: got %0d want 26", res_data); end
        total++; if (fill !== 4'd0)       begin bad++; $display("FAIL basic_fill_end: got %0d want 0", fill); end
        ack;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL basic_ack: got valid=%b busy=%b want 0 0", res_valid, busy); end
    endtask

    task automatic test_wrap;
        int lat;
        push(16'd300, 16'd300);
        run_start(lat);
        total++; if (lat !== 4)            begin bad++; $display("FAIL wrap_latency: got %0d want 4", lat); end
        total++; if (res_data !== 16'd24464) begin bad++; $display("FAIL wrap_result: got %0d want 24464", res_data); end
        ack;
    endtask

    task automatic test_empty;
        int lat;
        logic [WIDTH-1:0] seen;
        seen = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 20) begin
            seen = seen | mac_a | mac_b;
            tick;
            lat++;
        end
        if (res_valid !== 1'b1) lat = -1;
        total++; if (lat !== 2)          begin bad++; $display("FAIL empty_latency: got %0d want 2", lat); end
        total++; if (res_data !== 16'd0) begin bad++; $display("FAIL empty_result: got %0d want 0", res_data); end
        total++; if (seen !== 16'd0)     begin bad++; $display("FAIL empty_operands: got or=%0h want 0", seen); end
        ack;
    endtask

    task automatic test_full;
        int acc;
        int lat;
        acc = 0;
        in_valid = 1'b1; in_a = 16'd1; in_b = 16'd1;
        for (int i = 0; i < 9; i++) begin
            if (in_ready === 1'b1) acc++;
            tick;
        end
        total++; if (acc !== 8)          begin bad++; $display("FAIL full_accepted: got %0d want 8", acc); end
        total++; if (fill !== 4'd8)      begin bad++; $display("FAIL full_fill: got %0d want 8", fill); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        run_start(lat);
        total++; if (lat !== 11)         begin bad++; $display("FAIL full_latency: got %0d want 11", lat); end
        total++; if (res_data !== 16'd8) begin bad++; $display("FAIL full_result: got %0d want 8", res_data); end
        ack;
    endtask

    task automatic test_hold;
        int lat;
        push(16'd5, 16'd7);
        run_start(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL hold_latency: got %0d want 4", lat); end
        for (int i = 0; i < 5; i++) begin
            res_ready = 1'b0;
            start = (i == 2);
            total++; if (res_valid !== 1'b1)  begin bad++; $display("FAIL hold_valid: cycle %0d got %b want 1", i, res_valid); end
            total++; if (res_data !== 16'd35) begin bad++; $display("FAIL hold_data: cycle %0d got %0d want 35", i, res_data); end
            total++; if (busy !== 1'b1)       begin bad++; $display("FAIL hold_busy: cycle %0d got %b want 1", i, busy); end
            total++; if (mac_rst !== 1'b0)    begin bad++; $display("FAIL hold_mac_rst: cycle %0d got %b want 0", i, mac_rst); end
            tick;
        end
        start = 1'b0;
        ack;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL hold_release: got valid=%b busy=%b ready=%b want 0 0 1", res_valid, busy, in_ready); end
    endtask

    task automatic test_reset_mid;
        int lat;
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        push(16'd7, 16'd8);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        total++; if (mac_a !== 16'd3) begin bad++; $display("FAIL mid_feed2: got a=%0d want 3", mac_a); end
        rst = 1'b1;
        #1;
        total++; if (mac_rst !== 1'b1 || mac_a !== 16'd0 || in_ready !== 1'b0)
            begin bad++; $display("FAIL mid_rst_comb: got rst=%b a=%0d ready=%b want 1 0 0", mac_rst, mac_a, in_ready); end
        tick;
        total++; if (fill !== 4'd0)      begin bad++; $display("FAIL mid_fill: got %0d want 0", fill); end
        total++; if (res_valid !== 1'b0 || busy !== 1'b0 || mac_rst !== 1'b1)
            begin bad++; $display("FAIL mid_state: got valid=%b busy=%b rst=%b want 0 0 1", res_valid, busy, mac_rst); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_release: got in_ready=%b want 1", in_ready); end
        push(16'd7, 16'd6);
        total++; if (fill !== 4'd1)      begin bad++; $display("FAIL mid_refill: got %0d want 1", fill); end
        run_start(lat);
        total++; if (lat !== 4)           begin bad++; $display("FAIL mid_latency: got %0d want 4", lat); end
        total++; if (res_data !== 16'd42) begin bad++; $display("FAIL mid_result: got %0d want 42", res_data); end
        ack;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_empty;
        test_full;
        test_hold;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
